// File: rtl/spike_packet_driver.sv
// Spike packet driver: queues {last, axon} packets and turns each into Wishbone axon-select
// writes, plus an end-of-picture write when last is set. Macro SPIKE_DRV_ACK_TIMEOUT_EN adds an ack timeout.
module spike_packet_driver #(
    parameter logic [31:0] CHOOSE_WEIGHT_BASE = 32'h30000800,
    parameter logic [31:0] DONE_PIC_ADDR      = 32'h30000840,
    parameter logic [7:0]  ACK_TIMEOUT        = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_axon,
    input  logic        in_last,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy,
    output logic [15:0] pic_count,
    output logic        timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SPIKE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [8:0]  fifo_mem_q [0:7];
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]  count_q, count_d;
    logic        rdy_en_q;

    logic [1:0]  state_q, state_d;
    logic        cyc_q, cyc_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        last_q, last_d;
    logic [15:0] pic_q, pic_d;

    logic        push, pop, ack, tmo_hit;
    logic [8:0]  head;
    logic        unused_dat;

    // Ready looks only at registered occupancy, so a same-cycle pop never admits a ninth entry.
    assign in_ready = rdy_en_q && (count_q < 4'd8);
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == S_IDLE) && (count_q != 4'd0);
    assign head     = fifo_mem_q[rd_ptr_q];
    assign ack      = cyc_q && wbm_ack_i;

    assign unused_dat = ^{wbm_dat_i, ACK_TIMEOUT};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {in_last, in_axon};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 3'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 3'd1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

`ifdef SPIKE_DRV_ACK_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       tmo_err_q, tmo_err_d;

    assign tmo_hit = cyc_q && !wbm_ack_i && (tmo_cnt_q == ACK_TIMEOUT - 8'd1);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q;
        if (!cyc_q || wbm_ack_i || tmo_hit) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
        if (tmo_hit) begin
            tmo_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        last_d  = last_q;
        pic_d   = pic_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_SPIKE;
                    cyc_d   = 1'b1;
                    adr_d   = CHOOSE_WEIGHT_BASE + {26'd0, head[7:4], 2'b00};
                    dat_d   = 32'd1 << head[3:0];
                    last_d  = head[8];
                end
            end
            S_SPIKE: begin
                if (ack || tmo_hit) begin
                    cyc_d   = 1'b0;
                    state_d = last_q ? S_DONE : S_GAP;
                end
            end
            S_DONE: begin
                // DONE is entered with cyc low; its first cycle issues the end-of-picture write.
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    adr_d = DONE_PIC_ADDR;
                    dat_d = 32'h1;
                end else if (ack) begin
                    cyc_d   = 1'b0;
                    pic_d   = pic_q + 16'd1;
                    state_d = S_GAP;
                end else if (tmo_hit) begin
                    cyc_d   = 1'b0;
                    state_d = S_GAP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_en_q <= 1'b0;
            state_q  <= S_IDLE;
            cyc_q    <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            last_q   <= 1'b0;
            pic_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_en_q <= 1'b1;
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            last_q   <= last_d;
            pic_q    <= pic_d;
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = cyc_q;
    assign wbm_sel_o = cyc_q ? 4'hF : 4'h0;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign pic_count = pic_q;
    assign busy      = (state_q != S_IDLE) || (count_q != 4'd0);

endmodule

// File: doc/spike_packet_driver.md
SPIKE_PACKET_DRIVER -- requirements
Module: spike_packet_driver

Interface
REQ-001 SHALL have parameter CHOOSE_WEIGHT_BASE, default 32'h30000800: base of the axon-select word window (16 words).
REQ-002 SHALL have parameter DONE_PIC_ADDR, default 32'h30000840: end-of-picture register address.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 8'd255: maximum wait for wbm_ack_i, in cycles.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_axon (input, 8) and in_last (input, 1): spike packet stream; in_last marks the final spike of a picture.
REQ-007 SHALL have Wishbone master ports wbm_cyc_o (1), wbm_stb_o (1), wbm_we_o (1), wbm_sel_o (4), wbm_adr_o (32) and wbm_dat_o (32) as outputs, and wbm_ack_i (1) and wbm_dat_i (32) as inputs; wbm_dat_i is unused.
REQ-008 SHALL have outputs busy (1), pic_count (16) and timeout_err (1).

Function
REQ-009 SHALL buffer packets {in_last, in_axon} in an internal 8-entry FIFO; a push occurs when in_valid and in_ready are both high.
REQ-010 SHALL drive in_ready = (FIFO occupancy < 8); in_ready SHALL depend only on registered occupancy, so a simultaneous pop does not admit a 9th entry.
REQ-011 SHALL implement the FSM IDLE -> SPIKE -> (DONE if the packet's last bit is 1) -> GAP -> IDLE.
REQ-012 SHALL pop the FIFO head on the IDLE->SPIKE transition; the transition SHALL occur in the first cycle in IDLE with the FIFO non-empty.
REQ-013 SHALL, in SPIKE, write wbm_adr_o = CHOOSE_WEIGHT_BASE + 4*in_axon[7:4] and wbm_dat_o = 32'b1 << in_axon[3:0].
REQ-014 SHALL, in DONE, write wbm_adr_o = DONE_PIC_ADDR and wbm_dat_o = 32'h1, then increment pic_count modulo 2^16 (65535 wraps to 0).
REQ-015 SHALL, for every write, assert wbm_cyc_o, wbm_stb_o and wbm_we_o together with wbm_sel_o = 4'hF, and hold all of them plus wbm_adr_o and wbm_dat_o stable until the cycle wbm_ack_i is sampled high.
REQ-016 SHALL deassert cyc, stb and we on the clock edge that samples ack; at most one transaction SHALL be outstanding.
REQ-017 SHALL spend exactly one cycle in GAP with cyc low before returning to IDLE.
REQ-018 SHALL make minimum latency from the push handshake edge to the first stb-high cycle 2 cycles when the FIFO is empty and the FSM is in IDLE.
REQ-019 SHALL ignore wbm_ack_i while cyc is low.
REQ-020 SHALL drive busy = (state != IDLE) or (FIFO non-empty).

Reset
REQ-021 SHALL, while rst is high at a clock edge, reset: FSM to IDLE, FIFO empty, in_ready=0, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0, pic_count=0, timeout_err=0, busy=0.
REQ-022 SHALL, on reset asserted mid-transaction, drop cyc and stb at that edge, discard any queued packets, and never re-issue the transaction.
REQ-023 SHALL assert in_ready on the first edge after rst deasserts.

Configuration
REQ-024 SHALL honour the macro SPIKE_DRV_ACK_TIMEOUT_EN.
REQ-025 SHALL, with SPIKE_DRV_ACK_TIMEOUT_EN defined, count cycles with stb high and no ack; when the count reaches ACK_TIMEOUT it SHALL drop cyc/stb and set timeout_err sticky until reset.
REQ-026 SHALL, on an abandoned SPIKE, still proceed to DONE if last=1.
REQ-027 SHALL, on an abandoned DONE, not increment pic_count.
REQ-028 SHALL, without SPIKE_DRV_ACK_TIMEOUT_EN, wait indefinitely for ack, with timeout_err tied to 0 and no counter logic.

Verification
REQ-029 SHALL cover: push axon=8'h25 with last=0, ack one cycle after stb -> one write adr=32'h30000808, dat=32'h00000020, sel=F, pic_count stays 0.
REQ-030 SHALL cover: push axon=8'hFF with last=1 -> writes 32'h3000083C/32'h00008000 then 32'h30000840/32'h1, one GAP cycle, pic_count=1.
REQ-031 SHALL cover: slave withholds ack while 10 packets are pushed -> in_ready falls after 8 FIFO pushes plus 1 popped; no packet is lost or reordered once ack resumes.
REQ-032 SHALL cover: ack delayed 5 cycles -> adr, dat, cyc and stb stay stable for all 6 cycles; one transaction only.
REQ-033 SHALL cover: rst asserted in the second stb cycle -> cyc=0 next edge, busy=0, FIFO empty.
REQ-034 SHALL cover, with SPIKE_DRV_ACK_TIMEOUT_EN: no ack -> stb drops after 255 cycles, timeout_err=1; with last=1 the DONE write follows; pic_count=65535 plus a completed DONE -> 0.
